char_pattern_matcher: RTL

- Streaming matcher that consumes one 8-bit character per accepted beat and detects every occurrence of a fixed PLEN-character pattern, including overlapping occurrences.
- Each match pushes an event (end position plus running match count) into a small event FIFO, which drains over a valid/ready output.
- Sits directly downstream of the character source in the basic-verify environment.

---
 rtl/patmatch_pkg.sv | 24 ++
 rtl/char_pattern_matcher_if.sv | 29 ++
 rtl/patmatch_event_fifo.sv | 69 ++++++
 rtl/char_pattern_matcher.sv | 108 ++++++++++
 4 files changed

// File: rtl/patmatch_pkg.sv
// Shared types and helpers for the character pattern matcher.
// Optional build macro: PATMATCH_CASE_FOLD_EN (fold 'a'..'z' to upper case before compare).
package patmatch_pkg;

    localparam int unsigned POS_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 16;

    typedef logic [7:0] char_t;

    // Match event payload at the default counter widths.
    typedef struct packed {
        logic [POS_W_DEF-1:0] pos;
        logic [CNT_W_DEF-1:0] count;
    } event_t;

    // Map 'a'..'z' onto 'A'..'Z'; every other code passes through unchanged.
    function automatic char_t fold_upper(input char_t c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return char_t'(c - 8'h20);
        end
        return c;
    endfunction

endpackage

// File: rtl/char_pattern_matcher_if.sv
// Character input stream and match-event output stream of the pattern matcher.
interface char_pattern_matcher_if #(
    parameter int unsigned POS_W = 16,
    parameter int unsigned CNT_W = 16
) ();

    logic             i_flush;
    logic             i_valid;
    logic [7:0]       i_char;
    logic             i_ready;
    logic             o_valid;
    logic             o_ready;
    logic [POS_W-1:0] o_pos;
    logic [CNT_W-1:0] o_count;
    logic             o_overflow;

    // Character source and event consumer side.
    modport master (
        output i_flush, i_valid, i_char, o_ready,
        input  i_ready, o_valid, o_pos, o_count, o_overflow
    );

    // Matcher side.
    modport slave (
        input  i_flush, i_valid, i_char, o_ready,
        output i_ready, o_valid, o_pos, o_count, o_overflow
    );

endinterface

// File: rtl/patmatch_event_fifo.sv
// First-word fall-through event FIFO with synchronous clear and a sticky overflow flag.
module patmatch_event_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so push-while-full is legal then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[ADDR_W-1:0]];

    // Pointer update; clear wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (ADDR_W+1)'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= (ADDR_W+1)'(rd_ptr + 1'b1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    // Sticky flag for a push dropped because the FIFO was full with no pop; survives clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (!clr && push && full && !do_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/char_pattern_matcher.sv
// Streaming fixed-pattern matcher reporting every (overlapping) occurrence as a FIFO event.
// Optional build macro: PATMATCH_CASE_FOLD_EN (case-insensitive compare for 'a'..'z').
module char_pattern_matcher
    import patmatch_pkg::*;
#(
    parameter int unsigned         PLEN       = 3,
    parameter logic [8*PLEN-1:0]   PATTERN    = "ABA",
    parameter int unsigned         POS_W      = 16,
    parameter int unsigned         CNT_W      = 16,
    parameter int unsigned         FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    char_pattern_matcher_if.slave  bus
);

    localparam int unsigned WIN_W  = 8 * PLEN;
    localparam int unsigned FILL_W = $clog2(PLEN + 1);
    localparam int unsigned EV_W   = POS_W + CNT_W;

    logic [WIN_W-1:0]  win;
    logic [WIN_W-1:0]  cand;
    logic [WIN_W-1:0]  pat_cmp;
    logic [FILL_W-1:0] fill;
    logic [POS_W-1:0]  pos;
    logic [CNT_W-1:0]  match_cnt;
    char_t             in_char;
    logic              accept;
    logic              hit;
    logic              push;
    logic              pop;
    logic [EV_W-1:0]   fifo_din;
    logic [EV_W-1:0]   fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf;

`ifdef PATMATCH_CASE_FOLD_EN
    // Fold the incoming character and every pattern character to upper case.
    assign in_char = fold_upper(bus.i_char);

    // Pattern is constant, so this reduces to a folded constant.
    always_comb begin
        pat_cmp = PATTERN;
        for (int i = 0; i < int'(PLEN); i++) begin
            pat_cmp[8*i +: 8] = fold_upper(PATTERN[8*i +: 8]);
        end
    end
`else
    assign in_char = bus.i_char;
    assign pat_cmp = PATTERN;
`endif

    // Candidate window: the newest PLEN-1 stored characters followed by the current one.
    assign cand     = WIN_W'({win, in_char});
    assign accept   = bus.i_valid && !fifo_full;
    assign hit      = accept && (fill >= FILL_W'(PLEN - 1)) && (cand == pat_cmp);
    assign push     = hit && !bus.i_flush;
    assign pop      = !fifo_empty && bus.o_ready && !bus.i_flush;
    assign fifo_din = {pos, CNT_W'(match_cnt + 1'b1)};

    // Window, fill, position and match counters; flush beats any accepted character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win       <= '0;
            fill      <= '0;
            pos       <= '0;
            match_cnt <= '0;
        end else if (bus.i_flush) begin
            fill      <= '0;
            pos       <= '0;
            match_cnt <= '0;
        end else if (accept) begin
            win <= cand;
            if (fill != FILL_W'(PLEN)) begin
                fill <= FILL_W'(fill + 1'b1);
            end
            pos <= POS_W'(pos + 1'b1);
            if (hit) begin
                match_cnt <= CNT_W'(match_cnt + 1'b1);
            end
        end
    end

    patmatch_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .clr      (bus.i_flush),
        .push     (push),
        .din      (fifo_din),
        .pop      (pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // Event fields read as zero whenever no event is presented.
    assign bus.i_ready    = !fifo_full;
    assign bus.o_valid    = !fifo_empty;
    assign bus.o_pos      = fifo_empty ? '0 : fifo_dout[EV_W-1 -: POS_W];
    assign bus.o_count    = fifo_empty ? '0 : fifo_dout[CNT_W-1:0];
    assign bus.o_overflow = fifo_ovf;

endmodule
